// File: rtl/cpu_top_verify_pkg.sv
// Shared opcode, funct and ALU definitions for the
// single-cycle RV32I core.
package cpu_top_verify_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    // alt is instr[30]: selects SUB / SRA
    function automatic alu_op_t alu_decode(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_op_t op;
        unique case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two operand ports, one debug
// port, one write port; x0 hardwired to zero.
module cpu_regfile
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    output logic [31:0] rd1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd2,
    input  logic [4:0]  ra3,
    output logic [31:0] rd3
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
    assign rd3 = (ra3 == 5'd0) ? '0 : regs[ra3];

endmodule

// File: rtl/cpu_top_verify.sv
// Single-cycle RV32I integer core: decode, ALU and
// next-PC are combinational, commit on the rising edge.
module cpu_top_verify
    import cpu_top_verify_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_out,
    output logic [31:0] imem_addr,
    input  logic [4:0]  ra3,
    output logic [31:0] rd3
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        alt;

    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    alu_op_t     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    logic        br_taken;
    logic        rf_we;
    logic [31:0] rf_wd;

    assign opcode = imem_out[6:0];
    assign rd     = imem_out[11:7];
    assign f3     = imem_out[14:12];
    assign rs1    = imem_out[19:15];
    assign rs2    = imem_out[24:20];
    assign alt    = imem_out[30];

    assign imm_i = {{20{imem_out[31]}}, imem_out[31:20]};
    assign imm_b = {{19{imem_out[31]}}, imem_out[31],
                    imem_out[7], imem_out[30:25],
                    imem_out[11:8], 1'b0};
    assign imm_j = {{11{imem_out[31]}}, imem_out[31],
                    imem_out[19:12], imem_out[20],
                    imem_out[30:21], 1'b0};
    assign imm_u = {imem_out[31:12], 12'd0};

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    cpu_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (rf_we),
        .wa  (rd),
        .wd  (rf_wd),
        .ra1 (rs1),
        .rd1 (rs1_val),
        .ra2 (rs2),
        .rd2 (rs2_val),
        .ra3 (ra3),
        .rd3 (rd3)
    );

    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = rs1_val;
        alu_b  = rs2_val;
        unique case (opcode)
            OP_R: begin
                alu_op = alu_decode(f3, alt);
            end
            OP_I: begin
                alu_b  = imm_i;
                alu_op = alu_decode(f3, alt && f3 == F3_SR);
            end
            OP_LUI: begin
                alu_a = '0;
                alu_b = imm_u;
            end
            OP_AUIPC: begin
                alu_a = pc;
                alu_b = imm_u;
            end
            OP_JALR: begin
                alu_b = imm_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_y = '0;
        unique case (alu_op)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_SLL:  alu_y = alu_a << alu_b[4:0];
            ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_y = 32'($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        unique case (f3)
            F3_BEQ:  br_taken = rs1_val == rs2_val;
            F3_BNE:  br_taken = rs1_val != rs2_val;
            F3_BLT:  br_taken = $signed(rs1_val) < $signed(rs2_val);
            F3_BGE:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            F3_BLTU: br_taken = rs1_val < rs2_val;
            F3_BGEU: br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    // anything not listed (loads, stores, fence, system) is a NOP
    always_comb begin
        rf_we   = 1'b0;
        rf_wd   = alu_y;
        pc_next = pc_plus4;
        unique case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
                rf_we = 1'b1;
            end
            OP_JAL: begin
                rf_we   = 1'b1;
                rf_wd   = pc_plus4;
                pc_next = pc + imm_j;
            end
            OP_JALR: begin
                rf_we   = 1'b1;
                rf_wd   = pc_plus4;
                pc_next = {alu_y[31:1], 1'b0};
            end
            OP_BR: begin
                if (br_taken) begin
                    pc_next = pc + imm_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_cpu_top_verify.sv
// Scoreboard bench for cpu_top_verify: expected PCs and
// register values are queued, then popped as the core runs.
`timescale 1ns/100ps
module tb_cpu_top_verify;

    logic        clk;
    logic        rst;
    logic [31:0] imem_out;
    logic [31:0] imem_addr;
    logic [4:0]  ra3;
    logic [31:0] rd3;

    logic [31:0] mem [64];

    typedef struct {
        bit          is_reg;
        logic [4:0]  ra;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];

    int total;
    int bad;

    cpu_top_verify dut (
        .clk       (clk),
        .rst       (rst),
        .imem_out  (imem_out),
        .imem_addr (imem_addr),
        .ra3       (ra3),
        .rd3       (rd3)
    );

    assign imem_out = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0000_0013;
        end
    endtask

    task automatic push_pc(input logic [31:0] v);
        exp_t e;
        e.is_reg = 1'b0;
        e.ra     = '0;
        e.val    = v;
        sbq.push_back(e);
    endtask

    task automatic push_reg(input logic [4:0] r, input logic [31:0] v);
        exp_t e;
        e.is_reg = 1'b1;
        e.ra     = r;
        e.val    = v;
        sbq.push_back(e);
    endtask

    // one clock: pop the expected PC and compare after the edge
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0 || sbq[0].is_reg) begin
            check({tag, "_sbq_pc"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check($sformatf("%s_pc", tag), imem_addr, e.val);
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step($sformatf("%s%0d", tag, i));
        end
    endtask

    task automatic drain_regs(input string tag);
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            ra3 = e.ra;
            #0.1;
            check($sformatf("%s_x%0d", tag, e.ra), rd3, e.val);
        end
    endtask

    // assert reset between edges, check PC, release before next edge
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_rst_pc"}, imem_addr, 32'd0);
        ra3 = 5'd3;
        #0.1;
        check({tag, "_rst_x3"}, rd3, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        ra3   = '0;
        clear_mem();
        #2;

        // addi x1,x0,0; addi x2,x0,0; xor x3,x1,x2
        mem[0] = 32'h0000_0093;
        mem[1] = 32'h0000_0113;
        mem[2] = 32'h0020_C1B3;
        do_reset("t1");
        push_pc(32'd4);
        push_pc(32'd8);
        push_pc(32'd12);
        push_reg(5'd3, 32'h0000_0000);
        run("t1_", 3);
        drain_regs("t1");

        mem[0] = 32'hFFF0_0093;
        do_reset("t2");
        push_pc(32'd4);
        push_pc(32'd8);
        push_pc(32'd12);
        push_reg(5'd1, 32'hFFFF_FFFF);
        push_reg(5'd3, 32'hFFFF_FFFF);
        run("t2_", 3);
        drain_regs("t2");

        mem[1] = 32'h0FF0_0113;
        do_reset("t3");
        push_pc(32'd4);
        push_pc(32'd8);
        push_pc(32'd12);
        push_reg(5'd2, 32'h0000_00FF);
        push_reg(5'd3, 32'hFFFF_FF00);
        run("t3_", 3);
        drain_regs("t3");

        // mid-program reset after two instructions
        do_reset("t6");
        push_pc(32'd4);
        push_pc(32'd8);
        run("t6a_", 2);
        #2;
        rst = 1'b0;
        #0.5;
        check("t6_mid_pc", imem_addr, 32'd0);
        for (int r = 0; r < 32; r++) begin
            ra3 = 5'(r);
            #0.1;
            check($sformatf("t6_mid_x%0d", r), rd3, 32'd0);
        end
        #0.5;
        rst = 1'b1;
        push_pc(32'd4);
        push_pc(32'd8);
        push_pc(32'd12);
        push_reg(5'd1, 32'hFFFF_FFFF);
        push_reg(5'd3, 32'hFFFF_FF00);
        run("t6b_", 3);
        drain_regs("t6");

        // x0 write, sub/sra/srl/slt/sltu with x1 = -1
        clear_mem();
        mem[0] = 32'h0050_0013;
        mem[1] = 32'hFFF0_0093;
        mem[2] = 32'h0040_0313;
        mem[3] = 32'h4010_0233;
        mem[4] = 32'h4060_D2B3;
        mem[5] = 32'h0060_D433;
        mem[6] = 32'h0000_A4B3;
        mem[7] = 32'h0000_B533;
        do_reset("t4");
        for (int i = 1; i <= 8; i++) begin
            push_pc(32'(4 * i));
        end
        push_reg(5'd0,  32'h0000_0000);
        push_reg(5'd1,  32'hFFFF_FFFF);
        push_reg(5'd4,  32'h0000_0001);
        push_reg(5'd5,  32'hFFFF_FFFF);
        push_reg(5'd6,  32'h0000_0004);
        push_reg(5'd8,  32'h0FFF_FFFF);
        push_reg(5'd9,  32'h0000_0001);
        push_reg(5'd10, 32'h0000_0000);
        run("t4_", 8);
        drain_regs("t4");

        // beq, jal, lui, jalr, auipc, store-as-NOP
        clear_mem();
        mem[0] = 32'h0000_0463;
        mem[1] = 32'hFFF0_0093;
        mem[2] = 32'h0100_00EF;
        mem[4] = 32'h0000_1217;
        mem[5] = 32'h0020_A023;
        mem[6] = 32'h1234_5137;
        mem[7] = 32'h0050_81E7;
        do_reset("t5");
        push_pc(32'd8);
        push_pc(32'd24);
        push_pc(32'd28);
        push_pc(32'd16);
        push_pc(32'd20);
        push_pc(32'd24);
        push_reg(5'd1, 32'h0000_000C);
        push_reg(5'd2, 32'h1234_5000);
        push_reg(5'd3, 32'h0000_0020);
        push_reg(5'd4, 32'h0000_1010);
        push_reg(5'd0, 32'h0000_0000);
        run("t5_", 6);
        drain_regs("t5");

        check("sbq_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_top_verify.md
CPU_TOP_VERIFY -- requirements
Module: cpu_top_verify

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: imem_out  input  32  instruction word fetched from imem_addr, supplied externally in the same cycle.
REQ-004 SHALL have: imem_addr  output  32  current PC, byte address.
REQ-005 SHALL have: ra3  input  5  debug register-file read address.
REQ-006 SHALL have: rd3  output  32  combinational contents of register ra3.
REQ-007 SHALL have no parameters; XLEN fixed at 32.

Function
REQ-008 SHALL be a single-cycle RV32I integer core: decode and execute imem_out combinationally; commit rd write and PC update on the same rising edge.
REQ-009 SHALL drive imem_addr = PC combinationally from the PC register.
REQ-010 SHALL support R-type ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (opcode 0110011).
REQ-011 SHALL support I-type ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (opcode 0010011), with sign-extended 12-bit immediates.
REQ-012 SHALL support LUI, AUIPC, JAL, JALR (target with bit0 cleared), and BEQ, BNE, BLT, BGE, BLTU, BGEU.
REQ-013 Arithmetic SHALL wrap modulo 2^32; shifts SHALL use the low 5 bits of the shift amount; SLT/SLTI SHALL compare signed, SLTU/SLTIU unsigned.
REQ-014 Next PC SHALL be PC+4, except: taken branch -> PC+B-imm; JAL -> PC+J-imm; JALR -> (rs1+I-imm)&~1. JAL/JALR SHALL write PC+4 to rd.
REQ-015 Loads, stores, FENCE, SYSTEM and any unrecognised opcode SHALL execute as NOP: no register write, PC+4.
REQ-016 Register file SHALL hold 32x32 bits; x0 SHALL read 0 on every port and ignore writes.
REQ-017 rd3 SHALL reflect a register write from the first clock edge after that write; no internal bypass is required on rd3.
REQ-018 Writes SHALL occur at most once per cycle; an instruction reading a register written by the previous instruction SHALL see the new value.

Reset
REQ-019 While rst is 0, PC SHALL be 0 immediately and asynchronously, and imem_addr SHALL be 0.
REQ-020 Reset SHALL clear all registers x1..x31 to 0, so rd3 reads 0 for any ra3.
REQ-021 After rst deasserts, the first rising edge SHALL execute the instruction at address 0.
REQ-022 Reset asserted mid-execution SHALL abort the in-flight instruction with no register write.

Structure
REQ-023 A shared package SHALL hold opcode constants, funct3/funct7 values, and the ALU-operation enum.
REQ-024 The register file SHALL be a sub-module cpu_regfile, with two read ports, one debug read port (ra3/rd3), and one write port.
REQ-025 Decode, immediate generation, ALU and next-PC logic SHALL stay in cpu_top_verify.

Verification
REQ-026 Reset, then 0x00000093, 0x00000113, 0x0020C1B3 on successive cycles, ra3=3 -> rd3=0x00000000.
REQ-027 0xFFF00093 (addi x1,x0,-1), 0x00000113, 0x0020C1B3 (xor x3,x1,x2), ra3=3 -> rd3=0xFFFFFFFF.
REQ-028 0xFFF00093, 0x0FF00113 (addi x2,x0,255), 0x0020C1B3, ra3=3 -> rd3=0xFFFFFF00; imem_addr shall advance 0,4,8,12.
REQ-029 addi x0,x0,5 then ra3=0 -> rd3=0; sub and sra with x1=-1 shall give signed results (sra x1 by 4 -> 0xFFFFFFFF).
REQ-030 beq x0,x0,+8 at PC=0 -> imem_addr=8; jal x1,+16 at PC=8 -> imem_addr=24 and x1=12.
REQ-031 Assert rst mid-program -> imem_addr=0 and all registers read 0 at once; execution shall resume from address 0 after release.
